// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [6:0]        OPC_SYSTEM  = 7'b1110011;
    localparam logic [INST_W-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;

    // Memory slot encoding driven onto the memory sclk input.
    localparam logic PHASE_FETCH = 1'b1;
    localparam logic PHASE_DATA  = 1'b0;

    // True for the two SYSTEM encodings that stop fetching.
    function automatic logic is_halt_inst(input logic [INST_W-1:0] word);
        return (word[6:0] == OPC_SYSTEM) &&
               ((word == INST_ECALL) || (word == INST_EBREAK));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: memory slot/address/data, redirect from execute,
// valid/ready instruction handshake toward decode, and the halt flag.
//   master : fetch_unit side
//   slave  : memory / execute / decode side
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic                 mem_phase;
    logic [ADDR_W-1:0]    fetch_addr;
    logic [INST_W-1:0]    mem_rdata;
    logic                 redirect_valid;
    logic [ADDR_W-1:0]    redirect_pc;
    logic                 inst_valid;
    logic [INST_W-1:0]    inst;
    logic [ADDR_W-1:0]    inst_pc;
    logic                 inst_ready;
    logic                 halted;

    modport master (
        output mem_phase, fetch_addr, inst_valid, inst, inst_pc, halted,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_phase, fetch_addr, inst_valid, inst, inst_pc, halted,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: synchronous FIFO of {instruction, pc} entries with flush.
// Head outputs are registered copies of the next-state head entry.
// Ports: clk, rst (async high); push/push_inst/push_pc; pop; flush;
//        count, head_valid, head_inst, head_pc.
// The caller never pushes into a full queue without a concurrent pop,
// and never pops an empty queue.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned PTR_W = $clog2(QDEPTH),
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output logic [INST_W-1:0] head_inst,
    output logic [ADDR_W-1:0] head_pc
);

    logic [INST_W-1:0] inst_mem_q [QDEPTH];
    logic [INST_W-1:0] inst_mem_d [QDEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [QDEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              head_valid_q, head_valid_d;
    logic [INST_W-1:0] head_inst_q, head_inst_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;

    // Next-state storage, pointers and registered head view.
    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = push_inst;
                pc_mem_d[wr_ptr_q]   = push_pc;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Empty queue presents zeros so stale entries never leak out.
        head_valid_d = (count_d != '0);
        head_inst_d  = head_valid_d ? inst_mem_d[rd_ptr_d] : '0;
        head_pc_d    = head_valid_d ? pc_mem_d[rd_ptr_d]   : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_mem_q   <= '{default: '0};
            pc_mem_q     <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_inst_q  <= '0;
            head_pc_q    <= '0;
        end else begin
            inst_mem_q   <= inst_mem_d;
            pc_mem_q     <= pc_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_inst_q  <= head_inst_d;
            head_pc_q    <= head_pc_d;
        end
    end

    assign count      = count_q;
    assign head_valid = head_valid_q;
    assign head_inst  = head_inst_q;
    assign head_pc    = head_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a unified memory.
// Alternates fetch/data memory slots every clock, owns the PC, buffers
// fetched words in fetch_queue toward decode, flushes on redirect and
// stops fetching after ECALL/EBREAK.
// Ports: clk, rst (async high); bus (fetch_unit_if.master) carrying
//        mem_phase, fetch_addr, mem_rdata, redirect_valid/pc,
//        inst_valid/inst/inst_pc/inst_ready, halted.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;

    logic [CNT_W-1:0]  q_count;
    logic              q_valid;
    logic [INST_W-1:0] q_inst;
    logic [ADDR_W-1:0] q_pc;

    logic              pop_c;
    logic              capture_c;
    logic              unused_redirect_lo;

    // Decode handshake and fetch-slot capture decision.
    always_comb begin
        pop_c     = q_valid && bus.inst_ready;
        capture_c = (phase_q == PHASE_FETCH) && !bus.redirect_valid &&
                    !halted_q && ((q_count < CNT_W'(QDEPTH)) || pop_c);
    end

    // Phase toggles unconditionally; redirect outranks capture.
    always_comb begin
        phase_d  = ~phase_q;
        pc_d     = pc_q;
        halted_d = halted_q;

        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            halted_d = 1'b0;
        end else if (capture_c) begin
            pc_d = pc_q + ADDR_W'(4);
            if (is_halt_inst(bus.mem_rdata)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PHASE_DATA;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // A pop concurrent with a redirect is absorbed by the flush.
    fetch_queue #(
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (capture_c),
        .push_inst  (bus.mem_rdata),
        .push_pc    (pc_q),
        .pop        (pop_c && !bus.redirect_valid),
        .flush      (bus.redirect_valid),
        .count      (q_count),
        .head_valid (q_valid),
        .head_inst  (q_inst),
        .head_pc    (q_pc)
    );

    // Redirect targets are word aligned; the low bits are dropped.
    assign unused_redirect_lo = ^bus.redirect_pc[1:0];

    assign bus.mem_phase  = phase_q;
    assign bus.fetch_addr = pc_q;
    assign bus.inst_valid = q_valid;
    assign bus.inst       = q_inst;
    assign bus.inst_pc    = q_pc;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for async
// reset and PC wrap, then random traffic against a queue-based model.
module tb_fetch_unit;

    localparam int QDEPTH = 2;

    logic clk;
    logic rst;

    logic [31:0] mem_words [64];

    fetch_unit_if #(.ADDR_W(8)) bus ();
    fetch_unit_if #(.ADDR_W(8)) bus_w ();

    fetch_unit #(.ADDR_W(8), .QDEPTH(QDEPTH), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.ADDR_W(8), .QDEPTH(QDEPTH), .RESET_PC(8'hFC)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    assign bus.mem_rdata   = mem_words[bus.fetch_addr[7:2]];
    assign bus_w.mem_rdata = mem_words[bus_w.fetch_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: instruction queue as an SV queue, plain PC arithmetic.
    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  pc;
    } ent_t;

    ent_t       m_q[$];
    logic [7:0] m_pc;
    logic       m_phase;
    logic       m_halted;

    task automatic model_reset();
        m_q.delete();
        m_pc     = 8'h00;
        m_phase  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        bit          pop;
        if (rst) begin
            model_reset();
        end else begin
            pop = (m_q.size() != 0) && bus.inst_ready;
            if (bus.redirect_valid) begin
                m_q.delete();
                m_pc     = bus.redirect_pc & 8'hFC;
                m_halted = 1'b0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_phase && !m_halted && m_q.size() < QDEPTH) begin
                    w = mem_words[m_pc[7:2]];
                    m_q.push_back('{inst: w, pc: m_pc});
                    if (w == 32'h0000_0073 || w == 32'h0010_0073) m_halted = 1'b1;
                    m_pc = m_pc + 8'd4;
                end
            end
            m_phase = !m_phase;
        end
    endtask

    task automatic model_compare(input string tag);
        check({tag, " valid"}, 32'(bus.inst_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check({tag, " inst"}, bus.inst, m_q[0].inst);
            check({tag, " inst_pc"}, 32'(bus.inst_pc), 32'(m_q[0].pc));
        end
        check({tag, " phase"}, 32'(bus.mem_phase), 32'(m_phase));
        check({tag, " fetch_addr"}, 32'(bus.fetch_addr), 32'(m_pc));
        check({tag, " halted"}, 32'(bus.halted), 32'(m_halted));
    endtask

    // One clock: model sees the same inputs as the DUT, sample #1 after edge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        model_compare(tag);
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        rv;
        logic [7:0]  rpc;
        logic        ev;
        logic [31:0] ei;
        logic [7:0]  ep;
        logic        eph;
        logic [7:0]  efa;
        logic        eh;
    } vec_t;

    function automatic vec_t vr(input logic r, input logic rdy, input logic rv,
                                input logic [7:0] rpc, input logic ev,
                                input logic [31:0] ei, input logic [7:0] ep,
                                input logic eph, input logic [7:0] efa,
                                input logic eh);
        vec_t v;
        v.rst = r; v.ready = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.ei = ei; v.ep = ep; v.eph = eph; v.efa = efa; v.eh = eh;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.inst_ready       = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = 8'h00;
        bus_w.inst_ready     = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = 8'h00;
        for (int i = 0; i < 64; i++) mem_words[i] = 32'h0000_0013;
        mem_words[0]  = 32'h0000_0033;
        mem_words[1]  = 32'h0000_2083;
        mem_words[2]  = 32'h0040_2103;
        mem_words[3]  = 32'h0010_0073;
        mem_words[8]  = 32'h0050_0293;
        mem_words[63] = 32'h00A0_0513;
        model_reset();

        //               rst rdy rv rpc    ev inst          ipc    ph fa     h
        tbl.push_back(vr(1, 1, 0, 8'h00, 0, 32'h0,         8'h00, 0, 8'h00, 0)); // 0
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 1, 8'h00, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 0, 8'h04, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 1, 8'h04, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0000_2083, 8'h04, 0, 8'h08, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 1, 8'h08, 0)); // 5
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0040_2103, 8'h08, 0, 8'h0C, 0));
        tbl.push_back(vr(1, 0, 0, 8'h00, 0, 32'h0,         8'h00, 0, 8'h00, 0));
        tbl.push_back(vr(0, 0, 0, 8'h00, 0, 32'h0,         8'h00, 1, 8'h00, 0));
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 0, 8'h04, 0));
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 1, 8'h04, 0)); // 10
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 0, 8'h08, 0));
        for (int k = 12; k <= 18; k++)
            tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_0033, 8'h00, logic'(k % 2 == 0), 8'h08, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0000_2083, 8'h04, 0, 8'h0C, 0)); // 19
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_2083, 8'h04, 1, 8'h0C, 0));
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_2083, 8'h04, 0, 8'h0C, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0040_2103, 8'h08, 1, 8'h0C, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0010_0073, 8'h0C, 0, 8'h10, 1));
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 1, 8'h10, 1));
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 0, 8'h10, 1)); // 25
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 1, 8'h10, 1));
        tbl.push_back(vr(0, 1, 0, 8'h00, 0, 32'h0,         8'h00, 0, 8'h10, 1));
        tbl.push_back(vr(0, 1, 1, 8'h00, 0, 32'h0,         8'h00, 1, 8'h00, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 0, 8'h04, 0));
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 1, 8'h04, 0)); // 30
        tbl.push_back(vr(0, 0, 0, 8'h00, 1, 32'h0000_0033, 8'h00, 0, 8'h08, 0));
        tbl.push_back(vr(0, 1, 1, 8'h23, 0, 32'h0,         8'h00, 1, 8'h20, 0));
        tbl.push_back(vr(0, 1, 0, 8'h00, 1, 32'h0050_0293, 8'h20, 0, 8'h24, 0));

        foreach (tbl[i]) begin
            rst                = tbl[i].rst;
            bus.inst_ready     = tbl[i].ready;
            bus.redirect_valid = tbl[i].rv;
            bus.redirect_pc    = tbl[i].rpc;
            tick($sformatf("row%0d model", i));
            check($sformatf("row%0d valid", i), 32'(bus.inst_valid), 32'(tbl[i].ev));
            if (tbl[i].ev || tbl[i].rst) begin
                check($sformatf("row%0d inst", i), bus.inst, tbl[i].ei);
                check($sformatf("row%0d inst_pc", i), 32'(bus.inst_pc), 32'(tbl[i].ep));
            end
            check($sformatf("row%0d phase", i), 32'(bus.mem_phase), 32'(tbl[i].eph));
            check($sformatf("row%0d fetch_addr", i), 32'(bus.fetch_addr), 32'(tbl[i].efa));
            check($sformatf("row%0d halted", i), 32'(bus.halted), 32'(tbl[i].eh));
        end

        // Async reset in the middle of a stall clears everything at once.
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        repeat (4) tick("stall");
        rst = 1'b1;
        #1;
        check("arst valid", 32'(bus.inst_valid), 32'd0);
        check("arst inst", bus.inst, 32'd0);
        check("arst inst_pc", 32'(bus.inst_pc), 32'd0);
        check("arst phase", 32'(bus.mem_phase), 32'd0);
        check("arst fetch_addr", 32'(bus.fetch_addr), 32'd0);
        check("arst halted", 32'(bus.halted), 32'd0);
        check("arst wrap fetch_addr", 32'(bus_w.fetch_addr), 32'h0000_00FC);
        check("arst wrap valid", 32'(bus_w.inst_valid), 32'd0);
        model_reset();
        tick("arst hold");
        rst            = 1'b0;
        bus.inst_ready = 1'b1;

        // Second instance starts at 0xFC and must wrap to 0x00.
        tick("wrap c2");
        check("wrap fetch_addr fc", 32'(bus_w.fetch_addr), 32'h0000_00FC);
        check("wrap phase", 32'(bus_w.mem_phase), 32'd1);
        tick("wrap c3");
        check("wrap valid", 32'(bus_w.inst_valid), 32'd1);
        check("wrap inst_pc fc", 32'(bus_w.inst_pc), 32'h0000_00FC);
        check("wrap inst fc", bus_w.inst, 32'h00A0_0513);
        check("wrap fetch_addr 00", 32'(bus_w.fetch_addr), 32'd0);
        tick("wrap c4");
        tick("wrap c5");
        check("wrap inst_pc 00", 32'(bus_w.inst_pc), 32'd0);
        check("wrap inst 00", bus_w.inst, 32'h0000_0033);

        // Random traffic over a random program with sprinkled halts.
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 11))
                0:       mem_words[i] = 32'h0000_0073;
                1:       mem_words[i] = 32'h0010_0073;
                default: mem_words[i] = $urandom;
            endcase
        end
        rst = 1'b1;
        tick("rand rst");
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.inst_ready     = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_pc    = 8'($urandom_range(0, 255));
            rst                = ($urandom_range(0, 399) == 0);
            tick($sformatf("rand%0d", c));
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the unified byte-addressed memory; consumes the memory's instruction-slot read data and feeds decode.
- Generates the memory phase signal that drives the memory's sclk input: 1 = instruction slot, 0 = data slot.
- Owns the PC and buffers fetched words in a small queue with a valid/ready handshake toward decode.
- Supports redirect (branch/jump flush) and halts on ECALL/EBREAK.

Parameters:
- ADDR_W, 8, memory byte-address width; PC width.
- QDEPTH, 2, prefetch queue entries (power of two, ≥2).
- RESET_PC, 0, PC value after reset (word aligned).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_phase  output  1  drives memory sclk; 1 = fetch slot, 0 = data slot.
- fetch_addr  output  ADDR_W  memory address during the fetch slot; equals the PC register.
- mem_rdata  input  32  memory data_out; sampled only at the end of a fetch slot.
- redirect_valid  input  1  flush request from execute (taken branch/jump).
- redirect_pc  input  ADDR_W  new PC; bits [1:0] ignored and forced to 0.
- inst_valid  output  1  queue head holds a valid instruction.
- inst  output  32  queue head instruction word.
- inst_pc  output  ADDR_W  byte address of the queue head instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- halted  output  1  ECALL/EBREAK fetched; fetching stopped.

Behaviour:
- Reset (async assert; deassert sampled on clk): mem_phase=0, pc=RESET_PC, count=0, halted=0, inst_valid=0, inst=0, inst_pc=0, all queue storage cleared.
- mem_phase toggles on every clk edge, unconditionally. Stall, halt and redirect never stop it.
- Capture condition at the rising edge ending a cycle with mem_phase=1: !redirect_valid && !halted && (count<QDEPTH || pop).
  - pop = inst_valid && inst_ready.
  - push writes {mem_rdata, pc} at the tail.
  - pc <= pc+4, modulo 2^ADDR_W. 0xFC wraps to 0x00 with no flag.
- If the capture condition fails, no push occurs and pc holds. The same address is refetched next fetch slot.
- Pop: head advances when inst_valid && inst_ready, including during a data-slot cycle.
- Simultaneous push and pop at count==QDEPTH is allowed; count is unchanged.
- Pop at count==0 is impossible, since inst_valid=0.
- inst_valid = (count!=0). inst and inst_pc come from registered head storage, with no combinational path from mem_rdata.
- Latency: reset release → first fetch slot is the 2nd cycle → inst_valid rises the following cycle (3rd cycle). Peak throughput is 1 instruction per 2 cycles.
- Redirect has the highest priority, in any phase:
  - count <= 0, pc <= {redirect_pc[ADDR_W-1:2],2'b00}, halted <= 0.
  - No push that cycle; a concurrent pop is discarded.
  - Next fetch slot uses the new pc.
- Halt: if the pushed word is 32'h00000073 (ECALL) or 32'h00100073 (EBREAK):
  - The word is pushed normally and halted <= 1 at the same edge.
  - pc still increments.
  - Queue continues draining to decode.
  - halted clears only on redirect or rst.
- Reset asserted mid-operation clears the queue and state immediately (asynchronous). Any partially stalled fetch is lost.
- fetch_addr = pc in both phases; the memory ignores it during the data slot.

Decomposition:
- Shared package:
  - INST_W=32.
  - OPC_SYSTEM=7'b1110011.
  - INST_ECALL=32'h00000073, INST_EBREAK=32'h00100073.
  - PHASE_FETCH=1'b1, PHASE_DATA=1'b0.
- One sub-module: fetch_queue. Synchronous FIFO of QDEPTH entries, each {INST_W, ADDR_W} wide, with push/pop/flush, count, and registered head outputs.
- pc, phase and halt logic stay in fetch_unit.

Test Plan:
- Reset, memory words 0x00000033/0x00002083/0x00402103 at 0/4/8, inst_ready=1 → inst_valid first high in cycle 3, with inst_pc 0x00, 0x04, 0x08 on every 2nd cycle and inst matching.
- inst_ready=0 held for 10 cycles → exactly QDEPTH=2 pushes (pc 0x00, 0x04), pc holds 0x08. Release ready → 0x08 fetched next fetch slot, no word lost or duplicated.
- Queue full, inst_ready=1 in the cycle mem_phase=1 → push and pop at the same edge, count stays 2, order preserved.
- redirect_valid=1, redirect_pc=0x23 with 2 entries queued and ready=1 → inst_valid=0 next cycle, next fetch_addr=0x20, first new inst_pc=0x20.
- EBREAK (0x00100073) at 0x0C → pushed with inst_pc 0x0C, halted=1, no push at 0x10. Redirect to 0x00 → halted=0 and fetching resumes.
- PC at 0xFC with RESET_PC=0xFC → next inst_pc is 0x00. Assert rst mid-stall → all outputs zero immediately, pc=RESET_PC.
